nibble_serial_adder_ctrl: RTL and testbench

//   Sequencer that computes a WIDTH-bit signed add/subtract by time-multiplexing one
//   4-bit ripple slice, one nibble per clock, LSB nibble first.
//   The carry is registered between nibbles. Two's-complement overflow is flagged.

---
 rtl/arith_pkg.sv | 14 +
 rtl/nibble_adder.sv | 38 +++
 rtl/nibble_serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the nibble-serial adder: slice width,
// sequencer states and the two's-complement overflow rule.
package arith_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic ovf_f(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple-carry slice built from four full adders; it has no overflow logic
// because the sequencer owns the sign decision.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_adder
   import arith_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout
);
   logic [NIB_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIB_W; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[NIB_W];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide signed add/subtract computed one nibble per clock, LSB nibble first,
// through a single shared 4-bit ripple slice with a registered carry.
module nibble_serial_adder_ctrl
   import arith_pkg::*;
#(
   parameter int NIBBLES = 4,
   localparam int W = NIB_W * NIBBLES
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   // Handshake: start (with sub/a/b) is taken only on an edge where busy=0;
   // busy stays high until the done cycle inclusive, and done is a one-cycle
   // pulse after which sum/cout/ovf hold until the next accepted start.
   seq_state_t       state_q, state_d;
   logic [W-1:0]     a_r, b_r;
   logic [IDX_W-1:0] idx_q;
   logic             carry_q;
   logic [W-1:0]     sum_q;
   logic             cout_q, ovf_q;
   logic [NIB_W-1:0] slice_a, slice_b, slice_sum;
   logic             slice_cout;
   logic             accept, last_nib;

   assign accept   = (state_q == IDLE) && start;
   assign last_nib = (idx_q == LAST_IDX);
   assign slice_a  = a_r[NIB_W*idx_q +: NIB_W];
   assign slice_b  = b_r[NIB_W*idx_q +: NIB_W];

   nibble_adder u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)    state_d = RUN;
         RUN:     if (last_nib) state_d = DONE;
         DONE:                  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= sub ? ~b : b;
         carry_q <= sub;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == RUN) begin
         sum_q[NIB_W*idx_q +: NIB_W] <= slice_sum;
         carry_q <= slice_cout;
         idx_q   <= idx_q + IDX_W'(1);
         if (last_nib) begin
            cout_q <= slice_cout;
            ovf_q  <= ovf_f(a_r[W-1], b_r[W-1], slice_sum[NIB_W-1]);
         end
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and random checks of the nibble-serial adder against an integer
// arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub_i = 1'b0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int checks = 0;
   int failures = 0;
   logic [W+1:0] exp_q[$];

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub_i),
      .a     (a_i),
      .b     (b_i),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
         $error("check %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed/unsigned integer arithmetic.
   task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf);
      int sa, sb, r, ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = int'(a);
      ub = int'(b);
      r = s ? (sa - sb) : (sa + sb);
      r_sum  = r[W-1:0];
      r_ovf  = (r > 32767) || (r < -32768);
      r_cout = s ? (ua >= ub) : ((ua + ub) > 65535);
   endtask

   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W-1:0] es;
      logic ec, eo;
      ref_op(a, b, s, es, ec, eo);
      exp_q.push_back({eo, ec, es});
   endtask

   // Present a request for one edge, then scramble the operand inputs.
   task automatic apply_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      @(negedge clk);
      a_i = a; b_i = b; sub_i = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
   endtask

   // Called in cycle 1 after acceptance; bounded wait for exactly one done.
   task automatic wait_done(input string tag);
      logic [W+1:0] e;
      int nd, dc;
      nd = 0; dc = 0;
      chk({tag, ".busy_run"}, W'(busy), W'(1));
      for (int c = 1; c <= NIBBLES + 3; c++) begin
         if (done) begin nd++; dc = c; end
         @(posedge clk); #1;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk({tag, ".done_count"}, W'(nd), W'(1));
      chk({tag, ".done_cycle"}, W'(dc), W'(NIBBLES + 1));
      chk({tag, ".sum"}, sum, e[W-1:0]);
      chk({tag, ".cout"}, W'(cout), W'(e[W]));
      chk({tag, ".ovf"}, W'(ovf), W'(e[W+1]));
      chk({tag, ".busy_idle"}, W'(busy), W'(0));
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      push_exp(a, b, s);
      apply_start(a, b, s);
      wait_done(tag);
   endtask

   initial begin
      logic [W-1:0] es;
      logic ec, eo;
      int nd, dc;

      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", W'(busy), W'(0));
      chk("rst.done", W'(done), W'(0));
      chk("rst.sum", sum, W'(0));
      chk("rst.cout", W'(cout), W'(0));
      chk("rst.ovf", W'(ovf), W'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_basic", 16'h1234, 16'h1111, 1'b0);
      run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0);
      run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
      run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1);

      // Directed spot-checks of the documented results.
      ref_op(16'h1234, 16'h1111, 1'b0, es, ec, eo);
      chk("ref.add_basic", es, 16'h2345);
      ref_op(16'h0005, 16'h0007, 1'b1, es, ec, eo);
      chk("ref.sub_borrow", es, 16'hFFFE);

      // start held high with changing operands through RUN and DONE.
      ref_op(16'h1111, 16'h2222, 1'b0, es, ec, eo);
      @(negedge clk);
      a_i = 16'h1111; b_i = 16'h2222; sub_i = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      nd = 0; dc = 0;
      for (int c = 1; c <= NIBBLES + 1; c++) begin
         a_i = W'($urandom); b_i = W'($urandom); sub_i = 1'($urandom);
         if (done) begin nd++; dc = c; end
         @(posedge clk); #1;
      end
      chk("hold.done_count", W'(nd), W'(1));
      chk("hold.done_cycle", W'(dc), W'(NIBBLES + 1));
      chk("hold.busy_idle", W'(busy), W'(0));
      chk("hold.sum", sum, es);
      chk("hold.cout", W'(cout), W'(ec));
      chk("hold.ovf", W'(ovf), W'(eo));
      a_i = 16'h0F0F; b_i = 16'h0101; sub_i = 1'b1;
      push_exp(16'h0F0F, 16'h0101, 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      a_i = W'($urandom); b_i = W'($urandom);
      wait_done("hold_next");

      // Reset in the second RUN cycle abandons the operation.
      apply_start(16'h1234, 16'h4321, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst.busy", W'(busy), W'(0));
      chk("midrst.done", W'(done), W'(0));
      chk("midrst.sum", sum, W'(0));
      chk("midrst.cout", W'(cout), W'(0));
      chk("midrst.ovf", W'(ovf), W'(0));
      nd = 0;
      for (int c = 0; c < NIBBLES + 3; c++) begin
         if (done || busy) nd++;
         @(posedge clk); #1;
      end
      chk("midrst.no_done", W'(nd), W'(0));
      run_op("after_rst", 16'h0010, 16'h0020, 1'b0);
      chk("after_rst.lit", sum, 16'h0030);

      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 4 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
         run_op("rand", ra, rb, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
